// File: rtl/vec_stream_pkg.sv
// rtl/vec_stream_pkg.sv - shared types and fixed-point constants for the vector stream path
package vec_stream_pkg;

    localparam int FP_I = 4;
    localparam int FP_Q = 12;

    localparam int DEF_WORKING_REGS = 4;
    localparam int DEF_NBITS        = 16;

    typedef logic signed [DEF_WORKING_REGS-1:0][DEF_NBITS-1:0] chunk_t;

    // Pointer width that stays legal when the indexed dimension has a single entry
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_packer.sv
// rtl/chunk_packer.sv - packs scalar samples into WorkingRegs-wide chunks
module chunk_packer
    import vec_stream_pkg::*;
#(
    parameter int WorkingRegs = 4,
    parameter int NBits       = 16
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              i_valid,
    input  logic [NBits-1:0]                  i_data,
    output logic                              o_chunk_done,
    output logic [WorkingRegs-1:0][NBits-1:0] o_chunk
);

    localparam int               LaneW    = ptr_width(WorkingRegs);
    localparam logic [LaneW-1:0] LastLane = LaneW'(WorkingRegs - 1);

    logic [LaneW-1:0]                  r_lane;
    logic [WorkingRegs-1:0][NBits-1:0] r_stage;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_lane <= '0;
        end else if (i_valid) begin
            r_lane <= (r_lane == LastLane) ? '0 : r_lane + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (i_valid) begin
            r_stage[r_lane] <= i_data;
        end
    end

    // The completing sample bypasses staging so the chunk lands in the bank on its accept edge
    always_comb begin
        o_chunk         = r_stage;
        o_chunk[r_lane] = i_data;
        o_chunk_done    = i_valid && (r_lane == LastLane);
    end

endmodule

// File: rtl/vec_chunk_feeder.sv
// rtl/vec_chunk_feeder.sv - ping-pong vector buffer presenting chunks to the vector MAC
module vec_chunk_feeder
    import vec_stream_pkg::*;
#(
    parameter int InVecLength = 16,
    parameter int WorkingRegs = 4,
    parameter int NBits       = 16
) (
    input  logic                                    clk_in,
    input  logic                                    rst_in,
    input  logic                                    s_valid_in,
    input  logic signed [NBits-1:0]                 s_data_in,
    output logic                                    s_ready_out,
    input  logic                                    req_chunk_in,
    output logic                                    vec_ready_out,
    output logic signed [WorkingRegs-1:0][NBits-1:0] chunk_out,
    output logic                                    err_underflow_out
);

    localparam int                Chunks    = InVecLength / WorkingRegs;
    localparam int                ChunkW    = ptr_width(Chunks);
    localparam logic [ChunkW-1:0] LastChunk = ChunkW'(Chunks - 1);

    generate
        if ((InVecLength % WorkingRegs) != 0) begin : g_len_check
            $error("InVecLength must be a multiple of WorkingRegs");
        end
    endgenerate

    logic [WorkingRegs-1:0][NBits-1:0] r_bank [0:1][0:Chunks-1];
    logic [1:0]                        r_full;
    logic                              r_wr_bank;
    logic                              r_rd_bank;
    logic [ChunkW-1:0]                 r_wr_chunk;
    logic [ChunkW-1:0]                 r_rd_chunk;
    logic                              r_err;

    logic                              w_accept;
    logic                              w_chunk_done;
    logic [WorkingRegs-1:0][NBits-1:0] w_chunk;
    logic                              w_rd_ok;
    logic                              w_wr_last;
    logic                              w_rd_last;
    logic [1:0]                        w_full_nxt;

    assign s_ready_out       = !r_full[r_wr_bank];
    assign vec_ready_out     = r_full[r_rd_bank];
    assign chunk_out         = r_bank[r_rd_bank][r_rd_chunk];
    assign err_underflow_out = r_err;

    assign w_accept  = s_valid_in && s_ready_out;
    assign w_rd_ok   = req_chunk_in && vec_ready_out;
    assign w_wr_last = w_chunk_done && (r_wr_chunk == LastChunk);
    assign w_rd_last = w_rd_ok && (r_rd_chunk == LastChunk);

    chunk_packer #(
        .WorkingRegs (WorkingRegs),
        .NBits       (NBits)
    ) u_packer (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .i_valid      (w_accept),
        .i_data       (s_data_in),
        .o_chunk_done (w_chunk_done),
        .o_chunk      (w_chunk)
    );

    // Set and clear always target different banks: a bank is written only while not full
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_last) w_full_nxt[r_wr_bank] = 1'b1;
        if (w_rd_last) w_full_nxt[r_rd_bank] = 1'b0;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_full     <= '0;
            r_wr_bank  <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_wr_chunk <= '0;
            r_rd_chunk <= '0;
            r_err      <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            if (w_chunk_done) begin
                r_wr_chunk <= w_wr_last ? '0 : r_wr_chunk + 1'b1;
                if (w_wr_last) r_wr_bank <= !r_wr_bank;
            end
            if (w_rd_ok) begin
                r_rd_chunk <= w_rd_last ? '0 : r_rd_chunk + 1'b1;
                if (w_rd_last) r_rd_bank <= !r_rd_bank;
            end else if (req_chunk_in) begin
                r_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (w_chunk_done) begin
            r_bank[r_wr_bank][r_wr_chunk] <= w_chunk;
        end
    end

endmodule
